// File: rtl/rs_pkg.sv
// Shared defaults, ratio helper and packing-FSM state type for the RS output packer.
package rs_pkg;

    localparam int SW_DEFAULT      = 8;
    localparam int DW_DEFAULT      = 32;
    localparam int PAD_SYM_DEFAULT = 0;

    typedef enum logic {
        IDLE = 1'b0,
        PACK = 1'b1
    } pack_state_t;

    function automatic int ratio_of(input int sw, input int dw);
        return dw / sw;
    endfunction

endpackage

// File: rtl/rs_out_packer_if.sv
// Symbol-in / word-out handshake bundle of the RS output packer.
// The packer sits on the slave modport; the symbol source / word sink uses master.
interface rs_out_packer_if
    import rs_pkg::*;
#(
    parameter int SW = SW_DEFAULT,
    parameter int DW = DW_DEFAULT
);
    logic [SW-1:0] sym_in;
    logic          sym_vld;
    logic          sym_sop;
    logic          sym_eop;
    logic          sym_rdy;
    logic [DW-1:0] data;
    logic          data_vld;
    logic          data_sop;
    logic          data_eop;
    logic          data_rdy;
    logic          err;

    modport master (
        output sym_in, sym_vld, sym_sop, sym_eop, data_rdy,
        input  sym_rdy, data, data_vld, data_sop, data_eop, err
    );

    modport slave (
        input  sym_in, sym_vld, sym_sop, sym_eop, data_rdy,
        output sym_rdy, data, data_vld, data_sop, data_eop, err
    );
endinterface

// File: rtl/rs_out_reg.sv
// Single-entry valid/ready output holding register carrying a packed word and its sop/eop flags.
module rs_out_reg
    import rs_pkg::*;
#(
    parameter int DW = DW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [DW-1:0] load_data,
    input  logic          load_sop,
    input  logic          load_eop,
    input  logic          data_rdy,
    output logic [DW-1:0] data,
    output logic          data_vld,
    output logic          data_sop,
    output logic          data_eop,
    output logic          ready
);
    // Space is available when empty or when the held word leaves this cycle.
    assign ready = !data_vld || data_rdy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data     <= '0;
            data_vld <= 1'b0;
            data_sop <= 1'b0;
            data_eop <= 1'b0;
        end else if (load) begin
            data     <= load_data;
            data_vld <= 1'b1;
            data_sop <= load_sop;
            data_eop <= load_eop;
        end else if (data_rdy) begin
            data_vld <= 1'b0;
            data_sop <= 1'b0;
            data_eop <= 1'b0;
        end
    end
endmodule

// File: rtl/rs_out_packer.sv
// Packs sop/eop-framed SW-bit RS symbols into DW-bit words, first symbol in the MSBs, padding partial tails.
// Optional RS_PACK_STAT_EN adds codeword and error statistic counters.
module rs_out_packer
    import rs_pkg::*;
#(
    parameter int            SW      = SW_DEFAULT,
    parameter int            DW      = DW_DEFAULT,
    parameter logic [SW-1:0] PAD_SYM = SW'(PAD_SYM_DEFAULT)
) (
    input  logic          clk,
    input  logic          rst,
    rs_out_packer_if.slave bus
`ifdef RS_PACK_STAT_EN
    ,
    output logic [31:0]   stat_cw_cnt,
    output logic [15:0]   stat_err_cnt
`endif
);
    localparam int RATIO = ratio_of(SW, DW);
    localparam int CW    = $clog2(RATIO + 1);

    pack_state_t   state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [DW-1:0] acc_reg, acc_next;
    logic          sop_flag_reg, sop_flag_next;
    logic          err_reg, err_next;

    logic          out_ready;
    logic          out_vld;
    logic          out_sop;
    logic          out_eop;
    logic [DW-1:0] out_data;
    logic          load;

    logic          sym_accept;
    logic [CW-1:0] slot_idx;
    logic [CW-1:0] word_cnt;
    logic [DW-1:0] word_next;
    logic          word_sop;
    logic          word_done;

    assign sym_accept = bus.sym_vld && out_ready;
    // A sop always restarts at slot 0, discarding any partial word.
    assign slot_idx   = bus.sym_sop ? '0 : cnt_reg;
    assign word_cnt   = slot_idx + CW'(1);
    assign word_sop   = bus.sym_sop || sop_flag_reg;
    assign word_done  = (word_cnt == CW'(RATIO)) || bus.sym_eop;

    // Slot 0 write starts from an all-pad word so unfilled tail slots are already padded.
    genvar gi;
    generate
        for (gi = 0; gi < RATIO; gi++) begin : g_slot
            assign word_next[DW-1-gi*SW -: SW] =
                (slot_idx == CW'(gi)) ? bus.sym_in :
                (slot_idx == '0)      ? PAD_SYM    :
                                        acc_reg[DW-1-gi*SW -: SW];
        end
    endgenerate

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        acc_next      = acc_reg;
        sop_flag_next = sop_flag_reg;
        err_next      = 1'b0;
        load          = 1'b0;
        if (sym_accept) begin
            if (state_reg == IDLE && !bus.sym_sop) begin
                err_next = 1'b1;
            end else begin
                err_next = (state_reg == PACK) && bus.sym_sop;
                if (word_done) begin
                    load          = 1'b1;
                    cnt_next      = '0;
                    acc_next      = '0;
                    sop_flag_next = 1'b0;
                    state_next    = bus.sym_eop ? IDLE : PACK;
                end else begin
                    cnt_next      = word_cnt;
                    acc_next      = word_next;
                    sop_flag_next = word_sop;
                    state_next    = PACK;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            acc_reg      <= '0;
            sop_flag_reg <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            acc_reg      <= acc_next;
            sop_flag_reg <= sop_flag_next;
            err_reg      <= err_next;
        end
    end

    rs_out_reg #(.DW(DW)) u_out_reg (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_data (word_next),
        .load_sop  (word_sop),
        .load_eop  (bus.sym_eop),
        .data_rdy  (bus.data_rdy),
        .data      (out_data),
        .data_vld  (out_vld),
        .data_sop  (out_sop),
        .data_eop  (out_eop),
        .ready     (out_ready)
    );

    assign bus.sym_rdy  = out_ready;
    assign bus.data     = out_data;
    assign bus.data_vld = out_vld;
    assign bus.data_sop = out_sop;
    assign bus.data_eop = out_eop;
    assign bus.err      = err_reg;

`ifdef RS_PACK_STAT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_cw_cnt  <= '0;
            stat_err_cnt <= '0;
        end else begin
            if (out_vld && bus.data_rdy && out_eop)
                stat_cw_cnt <= stat_cw_cnt + 32'd1;
            if (err_reg)
                stat_err_cnt <= stat_err_cnt + 16'd1;
        end
    end
`endif

endmodule
